// File: rtl/fifo_pkt_writer_if.sv
// fifo_pkt_writer_if: upstream valid/ready word stream with end-of-packet marking
// Ports (signals):
//   s_valid  producer -> writer  word valid
//   s_ready  writer -> producer  word accepted when s_valid & s_ready
//   s_data   producer -> writer  DATA_WIDTH word
//   s_last   producer -> writer  marks the final body word of a packet
// Modports: master (stream producer), slave (fifo_pkt_writer).
interface fifo_pkt_writer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_last;
    modport master (output s_valid, s_data, s_last, input s_ready);
    modport slave  (input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/fifo_pkt_writer.sv
// fifo_pkt_writer: frames a valid/ready word stream as header(seq), body, trailer(count) into an async FIFO write port
// Ports:
//   wr_clk        write-domain clock
//   wr_rst_n      asynchronous active-low reset
//   s             fifo_pkt_writer_if.slave upstream stream (s_valid, s_ready, s_data, s_last)
//   fifo_wr_en    FIFO write strobe
//   fifo_wr_data  FIFO write word
//   fifo_full     registered FIFO full flag (wr_clk domain)
//   pkt_done      one-cycle pulse when the final frame word is loaded
//   pkt_trunc     one-cycle pulse when a packet reaches MAX_LEN without s_last
//   busy          high while a packet is in flight or the output register holds a word
// Build option: PKT_WRITER_CHK_EN appends an XOR checksum word after the trailer.
module fifo_pkt_writer #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_LEN    = 64,
    localparam int CNT_WIDTH = $clog2(MAX_LEN + 1)
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst_n,
    fifo_pkt_writer_if.slave      s,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
    input  logic                  fifo_full,
    output logic                  pkt_done,
    output logic                  pkt_trunc,
    output logic                  busy
);
`ifdef PKT_WRITER_CHK_EN
    typedef enum logic [2:0] {IDLE, BODY, TRL, DROP, CHK} state_t;
    logic [DATA_WIDTH-1:0] chk;
`else
    typedef enum logic [1:0] {IDLE, BODY, TRL, DROP} state_t;
`endif
    state_t                state, nxt;
    logic                  out_vld, out_free, load, ready, trunc_flag, seq_inc;
    logic [DATA_WIDTH-1:0] out_data, load_data, seq;
    logic [CNT_WIDTH-1:0]  cnt;

    assign fifo_wr_en   = out_vld & ~fifo_full;
    assign fifo_wr_data = out_data;
    assign out_free     = ~out_vld | fifo_wr_en;
    assign busy         = (state != IDLE) | out_vld;
    assign s.s_ready    = ready;

    always_comb begin
        nxt       = state;
        ready     = 1'b0;
        load      = 1'b0;
        load_data = out_data;
        pkt_done  = 1'b0;
        pkt_trunc = 1'b0;
        seq_inc   = 1'b0;
        case (state)
            IDLE: if (s.s_valid && out_free) begin
                load      = 1'b1;
                load_data = seq;
                nxt       = BODY;
            end
            BODY: begin
                ready = out_free;
                if (s.s_valid && out_free) begin
                    load      = 1'b1;
                    load_data = s.s_data;
                    if (s.s_last) nxt = TRL;
                    else if (cnt == CNT_WIDTH'(MAX_LEN - 1)) begin
                        pkt_trunc = 1'b1;
                        nxt       = TRL;
                    end
                end
            end
            TRL: if (out_free) begin
                load      = 1'b1;
                load_data = DATA_WIDTH'(cnt);
                seq_inc   = 1'b1;
`ifdef PKT_WRITER_CHK_EN
                nxt       = CHK;
`else
                pkt_done  = 1'b1;
                nxt       = trunc_flag ? DROP : IDLE;
`endif
            end
`ifdef PKT_WRITER_CHK_EN
            CHK: if (out_free) begin
                load      = 1'b1;
                load_data = chk;
                pkt_done  = 1'b1;
                nxt       = trunc_flag ? DROP : IDLE;
            end
`endif
            DROP: begin
                ready = 1'b1;
                if (s.s_valid && s.s_last) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state      <= IDLE;
            out_vld    <= 1'b0;
            out_data   <= '0;
            seq        <= '0;
            cnt        <= '0;
            trunc_flag <= 1'b0;
`ifdef PKT_WRITER_CHK_EN
            chk        <= '0;
`endif
        end else begin
            state <= nxt;
            if (load) begin
                out_vld  <= 1'b1;
                out_data <= load_data;
            end else if (fifo_wr_en) out_vld <= 1'b0;
            if (state == IDLE && load) begin
                cnt        <= '0;
                trunc_flag <= 1'b0;
`ifdef PKT_WRITER_CHK_EN
                chk        <= '0;
`endif
            end
            if (state == BODY && load) begin
                cnt <= cnt + CNT_WIDTH'(1);
`ifdef PKT_WRITER_CHK_EN
                chk <= chk ^ s.s_data;
`endif
            end
            if (pkt_trunc) trunc_flag <= 1'b1;
            if (seq_inc) seq <= seq + DATA_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_fifo_pkt_writer.sv
// tb_fifo_pkt_writer: scoreboard bench for fifo_pkt_writer with a packet-level reference model
module tb_fifo_pkt_writer;
    localparam int DW = 8;
    localparam int ML = 64;

    logic          wr_clk = 1'b0;
    logic          wr_rst_n = 1'b0;
    logic          fifo_wr_en, fifo_full = 1'b0, pkt_done, pkt_trunc, busy;
    logic [DW-1:0] fifo_wr_data;

    fifo_pkt_writer_if #(.DATA_WIDTH(DW)) sif ();

    fifo_pkt_writer #(.DATA_WIDTH(DW), .MAX_LEN(ML)) dut (
        .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .s(sif.slave),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full),
        .pkt_done(pkt_done), .pkt_trunc(pkt_trunc), .busy(busy)
    );

    always #5 wr_clk = ~wr_clk;

    int            errors = 0, checks = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] seq_m = 0;
    int            exp_done = 0, exp_trunc = 0, done_cnt = 0, trunc_cnt = 0;
    bit            rand_full = 0, force_full = 0, track = 0;
    int            cyc = 0, last_wr = 0, nwr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial forever begin
        @(posedge wr_clk);
        #1 fifo_full = force_full | (rand_full && $urandom_range(0, 4) == 0);
    end

    always @(negedge wr_clk) begin
        cyc++;
        if (fifo_wr_en) begin
            if (exp_q.size() == 0) chk("unexpected_write", {24'h0, fifo_wr_data}, 32'hFFFF_FFFF);
            else chk("fifo_word", {24'h0, fifo_wr_data}, {24'h0, exp_q.pop_front()});
            if (track) begin
                if (nwr > 0) chk("consecutive_write", cyc - last_wr, 1);
                last_wr = cyc;
                nwr++;
            end
        end
        if (fifo_full) chk("wr_en_while_full", {31'h0, fifo_wr_en}, 0);
        if (pkt_done) done_cnt++;
        if (pkt_trunc) trunc_cnt++;
    end

    // Reference model: a packet of n words frames as seq, first min(n,ML) words, min(n,ML), [xor]
    task automatic send_pkt(input logic [DW-1:0] d[$], input int gap);
        int            n = d.size();
        int            k = (n > ML) ? ML : n;
        logic [DW-1:0] x = 0;
        bit            acc;
        exp_q.push_back(seq_m);
        for (int i = 0; i < k; i++) begin
            exp_q.push_back(d[i]);
            x ^= d[i];
        end
        exp_q.push_back(DW'(k));
`ifdef PKT_WRITER_CHK_EN
        exp_q.push_back(x);
`endif
        seq_m++;
        exp_done++;
        if (n > ML) exp_trunc++;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 99) < gap) begin
                sif.s_valid = 0;
                repeat ($urandom_range(1, 3)) @(posedge wr_clk);
                #1;
            end
            sif.s_valid = 1;
            sif.s_data = d[i];
            sif.s_last = (i == n - 1);
            acc = 0;
            for (int t = 0; t < 2000 && !acc; t++) begin
                @(negedge wr_clk);
                acc = sif.s_ready;
                @(posedge wr_clk);
                #1;
            end
            if (!acc) chk("accept_timeout", 0, 1);
        end
        sif.s_valid = 0;
        sif.s_last = 0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 3000) begin
            @(negedge wr_clk);
            t++;
        end
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("drain_idle", {31'h0, busy}, 0);
        chk("pkt_done_count", done_cnt, exp_done);
        chk("pkt_trunc_count", trunc_cnt, exp_trunc);
        @(posedge wr_clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, {31'h0, sif.s_ready}, 0);
        chk({tag, "_wr_en"}, {31'h0, fifo_wr_en}, 0);
        chk({tag, "_wr_data"}, {24'h0, fifo_wr_data}, 0);
        chk({tag, "_pkt_done"}, {31'h0, pkt_done}, 0);
        chk({tag, "_pkt_trunc"}, {31'h0, pkt_trunc}, 0);
        chk({tag, "_busy"}, {31'h0, busy}, 0);
    endtask

    function automatic void rand_pkt(input int n, output logic [DW-1:0] d[$]);
        d = {};
        for (int i = 0; i < n; i++) d.push_back(DW'($urandom));
    endfunction

    initial begin
        logic [DW-1:0] d[$];
        logic [DW-1:0] held;
        sif.s_valid = 0;
        sif.s_data = 0;
        sif.s_last = 0;
        #2 check_reset_outputs("reset");
        @(posedge wr_clk);
        #1 wr_rst_n = 1;
        @(posedge wr_clk);
        #1;
        track = 1;
        nwr = 0;
        send_pkt('{8'hA1, 8'hA2, 8'hA3}, 0);
        drain();
        track = 0;
`ifdef PKT_WRITER_CHK_EN
        chk("pkt1_write_count", nwr, 6);
`else
        chk("pkt1_write_count", nwr, 5);
`endif
        send_pkt('{8'h0F, 8'hF0, 8'h33}, 0);
        drain();
        rand_pkt(ML, d);
        send_pkt(d, 0);
        drain();
        rand_pkt(70, d);
        send_pkt(d, 0);
        drain();
        rand_pkt(20, d);
        fork
            send_pkt(d, 0);
            begin
                repeat (6) @(negedge wr_clk);
                force_full = 1;
                @(posedge wr_clk);
                #2 held = fifo_wr_data;
                repeat (5) begin
                    @(negedge wr_clk);
                    chk("full_held", {31'h0, fifo_full}, 1);
                    chk("full_s_ready", {31'h0, sif.s_ready}, 0);
                    chk("full_data_stable", {24'h0, fifo_wr_data}, {24'h0, held});
                end
                force_full = 0;
            end
        join
        drain();
        rand_pkt(10, d);
        exp_q.push_back(seq_m);
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(d[i]);
            sif.s_valid = 1;
            sif.s_data = d[i];
            sif.s_last = 0;
            @(posedge wr_clk);
            #1;
            if (i == 0) begin
                @(posedge wr_clk);
                #1;
            end
        end
        sif.s_valid = 0;
        repeat (2) @(posedge wr_clk);
        #3;
        chk("pre_reset_written", exp_q.size(), 0);
        chk("pre_reset_busy", {31'h0, busy}, 1);
        wr_rst_n = 0;
        #1 check_reset_outputs("midreset");
        exp_q.delete();
        seq_m = 0;
        @(posedge wr_clk);
        #1 wr_rst_n = 1;
        @(posedge wr_clk);
        #1;
        send_pkt('{8'h55, 8'h66}, 0);
        drain();
        rand_full = 1;
        for (int p = 0; p < 30; p++) begin
            int n = (p % 10 == 0) ? 1 : (p % 10 == 1) ? ML - 1 : (p % 10 == 2) ? ML + 1 : $urandom_range(1, 80);
            rand_pkt(n, d);
            send_pkt(d, 30);
        end
        rand_full = 0;
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
